// File: rtl/csa_accumulator.sv
// Packet accumulator built around a carry-select adder: sums valid/ready beats until in_last.
// Optional feature: define SATURATE_EN to clamp the packet sum to all ones on the first adder carry-out.

module csa #(
   parameter int dataWidth = 32,
   parameter int nStage    = 4
) (
   input  logic [dataWidth-1:0] a,
   input  logic [dataWidth-1:0] b,
   input  logic                 ci,
   output logic [dataWidth-1:0] s,
   output logic                 co
);
   localparam int SW = dataWidth / nStage;

   genvar gi;
   generate
      for (gi = 0; gi < nStage; gi++) begin : g_stage
         logic [SW:0] sum0;
         logic [SW:0] sum1;
         logic        cin;
         logic        cout;

         // Each stage precomputes both carry-in cases; the ripple is only through the selects.
         if (gi == 0) begin : g_first
            assign cin = ci;
         end else begin : g_next
            assign cin = g_stage[gi-1].cout;
         end

         assign sum0 = {1'b0, a[gi*SW +: SW]} + {1'b0, b[gi*SW +: SW]};
         assign sum1 = sum0 + (SW+1)'(1);
         assign s[gi*SW +: SW] = cin ? sum1[SW-1:0] : sum0[SW-1:0];
         assign cout = cin ? sum1[SW] : sum0[SW];
      end
   endgenerate

   assign co = g_stage[nStage-1].cout;
endmodule

module csa_accumulator #(
   parameter int dataWidth = 32,
   parameter int nStage    = 4,
   parameter int cntWidth  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [dataWidth-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [dataWidth-1:0] out_sum,
   output logic [cntWidth-1:0]  out_carries,
   output logic [cntWidth-1:0]  out_count
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                state_reg, state_next;
   logic [dataWidth-1:0]  acc_reg, acc_next;
   logic [cntWidth-1:0]   carries_reg, carries_next;
   logic [cntWidth-1:0]   count_reg, count_next;
   logic [dataWidth-1:0]  csa_sum;
   logic                  csa_co;
   logic                  accept;
`ifdef SATURATE_EN
   logic                  sat_reg, sat_next;
`endif

   csa #(.dataWidth(dataWidth), .nStage(nStage)) u_csa (
      .a  (acc_reg),
      .b  (in_data),
      .ci (1'b0),
      .s  (csa_sum),
      .co (csa_co)
   );

   assign in_ready    = (state_reg != DONE);
   assign out_valid   = (state_reg == DONE);
   assign accept      = in_valid & in_ready;
   assign out_sum     = acc_reg;
   assign out_carries = carries_reg;
   assign out_count   = count_reg;

   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      carries_next = carries_reg;
      count_next   = count_reg;
`ifdef SATURATE_EN
      sat_next     = sat_reg;
`endif
      case (state_reg)
         IDLE, ACC: begin
            if (accept) begin
`ifdef SATURATE_EN
               if (sat_reg || csa_co) begin
                  acc_next = '1;
                  sat_next = 1'b1;
               end else begin
                  acc_next = csa_sum;
               end
`else
               acc_next = csa_sum;
`endif
               // Both counters stick at full scale rather than wrapping.
               if (csa_co && (carries_reg != '1))
                  carries_next = carries_reg + cntWidth'(1);
               if (count_reg != '1)
                  count_next = count_reg + cntWidth'(1);
               state_next = in_last ? DONE : ACC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next   = IDLE;
               acc_next     = '0;
               carries_next = '0;
               count_next   = '0;
`ifdef SATURATE_EN
               sat_next     = 1'b0;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         carries_reg <= '0;
         count_reg   <= '0;
`ifdef SATURATE_EN
         sat_reg     <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         carries_reg <= carries_next;
         count_reg   <= count_next;
`ifdef SATURATE_EN
         sat_reg     <= sat_next;
`endif
      end
   end
endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and randomised-stall bench for csa_accumulator; two instances (cntWidth 8 and 4) share stimulus.
// Expected results follow SATURATE_EN the same way the design does.

module tb_csa_accumulator;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic [31:0] in_data;

   logic        in_ready, out_valid;
   logic [31:0] out_sum;
   logic [7:0]  out_carries, out_count;
   logic        in_ready4, out_valid4;
   logic [31:0] out_sum4;
   logic [3:0]  out_carries4, out_count4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   csa_accumulator #(.dataWidth(32), .nStage(4), .cntWidth(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_carries(out_carries), .out_count(out_count)
   );

   csa_accumulator #(.dataWidth(32), .nStage(4), .cntWidth(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready), .out_sum(out_sum4),
      .out_carries(out_carries4), .out_count(out_count4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int sat_cnt(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat after 'gap' idle cycles; returns one step after the accepting edge.
   task automatic send_beat(input logic [31:0] d, input logic l, input int gap, input bit rnd_ready);
      int t;
      in_valid = 1'b0;
      repeat (gap) begin
         in_data = $urandom;
         step();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      step();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      in_data   = $urandom;
   endtask

   // Expects the result right after the last beat, holds out_ready low 'hold' cycles, then handshakes.
   task automatic collect(input string tag, input logic [31:0] e_sum, input int e_carr,
                          input int e_cnt, input int hold);
      int t;
      check({tag, "_latency"}, out_valid, 1);
      t = 0;
      while (!out_valid && t < 50) begin
         step();
         t++;
      end
      repeat (hold) begin
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_sum"}, out_sum, e_sum);
         check({tag, "_hold_in_ready"}, in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      check({tag, "_sum"}, out_sum, e_sum);
      check({tag, "_carries"}, out_carries, sat_cnt(e_carr, 255));
      check({tag, "_count"}, out_count, sat_cnt(e_cnt, 255));
      check({tag, "_valid4"}, out_valid4, 1);
      check({tag, "_sum4"}, out_sum4, e_sum);
      check({tag, "_carries4"}, out_carries4, sat_cnt(e_carr, 15));
      check({tag, "_count4"}, out_count4, sat_cnt(e_cnt, 15));
      $display("pkt %s: sum=0x%08h carries=%0d count=%0d", tag, out_sum, out_carries, out_count);
      step();
      out_ready = 1'b0;
      check({tag, "_post_valid"}, out_valid, 0);
      check({tag, "_post_in_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [31:0] m_sum, d;
      logic [32:0] wide;
      int          m_carr, len;
      bit          m_sat;

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
      step(); step();
      rst = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sum", out_sum, 0);
      check("rst_count", out_count, 0);
      check("rst_carries", out_carries, 0);

      // Partial packet discarded by reset.
      send_beat(32'd5, 1'b0, 0, 1'b0);
      send_beat(32'd7, 1'b0, 0, 1'b0);
      check("mid_count", out_count, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_sum", out_sum, 0);
      check("midrst_count", out_count4, 0);
      send_beat(32'd9, 1'b1, 0, 1'b0);
      collect("after_rst", 32'd9, 0, 1, 0);

      send_beat(32'h0000_00FF, 1'b1, 0, 1'b0);
      collect("single", 32'hFF, 0, 1, 0);

      for (int i = 1; i <= 4; i++) send_beat(i, (i == 4), 0, 1'b0);
      collect("four_beat", 32'd10, 0, 4, 3);

      send_beat(32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      send_beat(32'h0000_0002, 1'b1, 0, 1'b0);
`ifdef SATURATE_EN
      collect("overflow", 32'hFFFF_FFFF, 1, 2, 0);
`else
      collect("overflow", 32'h0000_0001, 1, 2, 0);
`endif

      for (int i = 0; i < 20; i++) send_beat(32'hFFFF_FFFF, (i == 19), 0, 1'b0);
`ifdef SATURATE_EN
      collect("cnt_sat", 32'hFFFF_FFFF, 19, 20, 0);
`else
      collect("cnt_sat", 32'hFFFF_FFEC, 19, 20, 0);
`endif

      // Random packets with idle gaps, random out_ready during accumulation and result stalls.
      for (int p = 0; p < 1000; p++) begin
         m_sum = '0; m_carr = 0; m_sat = 1'b0;
         len = $urandom_range(1, 8);
         for (int b = 0; b < len; b++) begin
            d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            wide = {1'b0, m_sum} + {1'b0, d};
            if (wide[32]) m_carr++;
`ifdef SATURATE_EN
            if (m_sat || wide[32]) begin
               m_sat = 1'b1;
               m_sum = '1;
            end else begin
               m_sum = wide[31:0];
            end
`else
            m_sum = wide[31:0];
`endif
            send_beat(d, (b == len - 1), $urandom_range(0, 2), 1'b1);
         end
         collect($sformatf("rnd%0d", p), m_sum, m_carr, len, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
